// File: rtl/dll_tx_arbiter.sv
// Shares the PIPE TX datapath between replay TLPs, new TLPs and DLLPs; switches owner only at packet boundaries.
// Output registered (1 cycle); readies are combinational and no PIPE backpressure exists.
module dll_tx_arbiter #(
  parameter int PIPE_DATA_WIDTH = 256,
  parameter int DLLP_BURST_MAX  = 4
) (
  input  logic                       sclk,
  input  logic                       srst_n,
  input  logic [1:0]                 dlcm_state_i,
  input  logic                       rpl_valid_i,
  input  logic [PIPE_DATA_WIDTH-1:0] rpl_data_i,
  input  logic                       rpl_sop_i,
  input  logic                       rpl_eop_i,
  output logic                       rpl_ready_o,
  input  logic                       tlp_valid_i,
  input  logic [PIPE_DATA_WIDTH-1:0] tlp_data_i,
  input  logic                       tlp_sop_i,
  input  logic                       tlp_eop_i,
  output logic                       tlp_ready_o,
  input  logic                       dllp_valid_i,
  input  logic [PIPE_DATA_WIDTH-1:0] dllp_data_i,
  output logic                       dllp_ready_o,
  output logic [PIPE_DATA_WIDTH-1:0] pipe_txdata_o,
  output logic                       pipe_txvalid_o,
  output logic [1:0]                 grant_o,
  output logic                       proto_err_o
);

  localparam int               CNT_W     = $clog2(DLLP_BURST_MAX + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(DLLP_BURST_MAX);

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_DLLP = 2'd1;
  localparam logic [1:0] GNT_RPL  = 2'd2;
  localparam logic [1:0] GNT_TLP  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOCK_RPL,
    S_LOCK_TLP
  } state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           burst_cnt_q, burst_cnt_d;
  logic [PIPE_DATA_WIDTH-1:0] txdata_q, txdata_d;
  logic                       txvalid_q, txvalid_d;
  logic [1:0]                 grant_q, grant_d;
  logic                       err_q, err_d;

  logic link_active, link_init;
  logic tlp_pend, tlp_sel;
  logic rpl_gnt, tlp_gnt, dllp_gnt;

  assign link_active = (dlcm_state_i == 2'b10);
  assign link_init   = (dlcm_state_i == 2'b01);
  assign tlp_pend    = link_active & (rpl_valid_i | tlp_valid_i);
  // A waiting TLP wins once DLLPs have used up their burst allowance.
  assign tlp_sel     = tlp_pend & ((burst_cnt_q == BURST_MAX) | ~dllp_valid_i);

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    txvalid_d   = 1'b0;
    txdata_d    = txdata_q;
    grant_d     = GNT_NONE;
    err_d       = 1'b0;
    rpl_gnt     = 1'b0;
    tlp_gnt     = 1'b0;
    dllp_gnt    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (link_init) begin
          dllp_gnt = dllp_valid_i;
        end else if (link_active) begin
          if (tlp_sel) begin
            rpl_gnt = rpl_valid_i;
            tlp_gnt = tlp_valid_i & ~rpl_valid_i;
          end else begin
            dllp_gnt = dllp_valid_i;
          end
        end

        if (dllp_gnt && tlp_pend) begin
          if (burst_cnt_q != BURST_MAX) burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end else if (!tlp_pend) begin
          burst_cnt_d = '0;
        end

        if (dllp_gnt) begin
          txvalid_d = 1'b1;
          txdata_d  = dllp_data_i;
          grant_d   = GNT_DLLP;
        end else if (rpl_gnt) begin
          if (rpl_sop_i) begin
            txvalid_d   = 1'b1;
            txdata_d    = rpl_data_i;
            grant_d     = GNT_RPL;
            burst_cnt_d = '0;
            if (!rpl_eop_i) state_d = S_LOCK_RPL;
          end else begin
            err_d = 1'b1;
          end
        end else if (tlp_gnt) begin
          if (tlp_sop_i) begin
            txvalid_d   = 1'b1;
            txdata_d    = tlp_data_i;
            grant_d     = GNT_TLP;
            burst_cnt_d = '0;
            if (!tlp_eop_i) state_d = S_LOCK_TLP;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_LOCK_RPL: begin
        rpl_gnt = rpl_valid_i;
        if (rpl_valid_i) begin
          txvalid_d = 1'b1;
          txdata_d  = rpl_data_i;
          grant_d   = GNT_RPL;
          err_d     = rpl_sop_i;
          if (rpl_eop_i) state_d = S_IDLE;
        end
      end

      S_LOCK_TLP: begin
        tlp_gnt = tlp_valid_i;
        if (tlp_valid_i) begin
          txvalid_d = 1'b1;
          txdata_d  = tlp_data_i;
          grant_d   = GNT_TLP;
          err_d     = tlp_sop_i;
          if (tlp_eop_i) state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (!srst_n) begin
      state_q     <= S_IDLE;
      burst_cnt_q <= '0;
      txdata_q    <= '0;
      txvalid_q   <= 1'b0;
      grant_q     <= GNT_NONE;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      txdata_q    <= txdata_d;
      txvalid_q   <= txvalid_d;
      grant_q     <= grant_d;
      err_q       <= err_d;
    end
  end

  assign rpl_ready_o    = rpl_gnt;
  assign tlp_ready_o    = tlp_gnt;
  assign dllp_ready_o   = dllp_gnt;
  assign pipe_txdata_o  = txdata_q;
  assign pipe_txvalid_o = txvalid_q;
  assign grant_o        = grant_q;
  assign proto_err_o    = err_q;

endmodule

// File: tb/tb_dll_tx_arbiter.sv
// Directed bench for dll_tx_arbiter: inputs change 1ns after posedge, readies checked at negedge, registered outputs after the next posedge.
module tb_dll_tx_arbiter;

  localparam int W = 256;

  logic         sclk = 1'b0;
  logic         srst_n;
  logic [1:0]   dlcm_state;
  logic         rpl_valid, rpl_sop, rpl_eop, rpl_ready;
  logic [W-1:0] rpl_data;
  logic         tlp_valid, tlp_sop, tlp_eop, tlp_ready;
  logic [W-1:0] tlp_data;
  logic         dllp_valid, dllp_ready;
  logic [W-1:0] dllp_data;
  logic [W-1:0] txdata;
  logic         txvalid;
  logic [1:0]   grant;
  logic         proto_err;

  int n_tests = 0;
  int n_fail  = 0;

  dll_tx_arbiter #(.PIPE_DATA_WIDTH(W), .DLLP_BURST_MAX(4)) dut (
    .sclk          (sclk),
    .srst_n        (srst_n),
    .dlcm_state_i  (dlcm_state),
    .rpl_valid_i   (rpl_valid),
    .rpl_data_i    (rpl_data),
    .rpl_sop_i     (rpl_sop),
    .rpl_eop_i     (rpl_eop),
    .rpl_ready_o   (rpl_ready),
    .tlp_valid_i   (tlp_valid),
    .tlp_data_i    (tlp_data),
    .tlp_sop_i     (tlp_sop),
    .tlp_eop_i     (tlp_eop),
    .tlp_ready_o   (tlp_ready),
    .dllp_valid_i  (dllp_valid),
    .dllp_data_i   (dllp_data),
    .dllp_ready_o  (dllp_ready),
    .pipe_txdata_o (txdata),
    .pipe_txvalid_o(txvalid),
    .grant_o       (grant),
    .proto_err_o   (proto_err)
  );

  always #5 sclk = ~sclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge sclk);
    #1;
  endtask

  task automatic half();
    @(negedge sclk);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [63:0] d, input logic [1:0] g);
    chk({tag, ".valid"}, txvalid, v);
    chk({tag, ".data"}, txdata[63:0], d);
    chk({tag, ".grant"}, grant, g);
  endtask

  logic [63:0] rpl_tab_d [3];
  logic        rpl_tab_s [3];
  logic        rpl_tab_e [3];

  initial begin
    srst_n = 1'b0; dlcm_state = 2'b00;
    rpl_valid = 0; rpl_sop = 0; rpl_eop = 0; rpl_data = '0;
    tlp_valid = 0; tlp_sop = 0; tlp_eop = 0; tlp_data = '0;
    dllp_valid = 0; dllp_data = '0;
    cyc(); cyc();

    // reset state
    chk_out("reset", 1'b0, 64'h0, 2'd0);
    chk("reset.err", proto_err, 1'b0);

    // DLLP stream with no TLPs
    srst_n = 1'b1; dlcm_state = 2'b10; dllp_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dllp_data = W'(64'hD0 + i);
      half();
      chk("dllp_stream.ready", dllp_ready, 1'b1);
      chk("dllp_stream.burst_cnt", dut.burst_cnt_q, 0);
      cyc();
      chk_out("dllp_stream", 1'b1, 64'hD0 + i, 2'd1);
    end
    dllp_valid = 1'b0;
    cyc();
    chk_out("idle_hold", 1'b0, 64'hD3, 2'd0);

    // 3-beat new TLP, DLLP arrives on beat 2
    tlp_valid = 1; tlp_sop = 1; tlp_eop = 0; tlp_data = W'(64'hA);
    half(); chk("tlp3.rdyA", tlp_ready, 1'b1);
    cyc();  chk_out("tlp3.A", 1'b1, 64'hA, 2'd3);
    tlp_sop = 0; tlp_data = W'(64'hB); dllp_valid = 1; dllp_data = W'(64'hD9);
    half(); chk("tlp3.dllp_blockB", dllp_ready, 1'b0);
    cyc();  chk_out("tlp3.B", 1'b1, 64'hB, 2'd3);
    tlp_eop = 1; tlp_data = W'(64'hC);
    half(); chk("tlp3.dllp_blockC", dllp_ready, 1'b0);
    chk("tlp3.rdyC", tlp_ready, 1'b1);
    cyc();  chk_out("tlp3.C", 1'b1, 64'hC, 2'd3);
    tlp_valid = 0; tlp_eop = 0;
    half(); chk("tlp3.dllp_after", dllp_ready, 1'b1);
    cyc();  chk_out("tlp3.dllp", 1'b1, 64'hD9, 2'd1);
    dllp_valid = 0;
    cyc();

    // DLLP vs single-beat TLP starvation bound: D,D,D,D,T
    dllp_valid = 1; dllp_data = W'(64'hDD);
    tlp_valid = 1; tlp_sop = 1; tlp_eop = 1; tlp_data = W'(64'h77);
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (k % 5 == 4) chk_out("burst.T", 1'b1, 64'h77, 2'd3);
      else            chk_out("burst.D", 1'b1, 64'hDD, 2'd1);
    end
    dllp_valid = 0; tlp_valid = 0;
    cyc(); cyc();

    // replay strictly ahead of new TLPs
    rpl_tab_d[0] = 64'h11; rpl_tab_s[0] = 1; rpl_tab_e[0] = 0;
    rpl_tab_d[1] = 64'h12; rpl_tab_s[1] = 0; rpl_tab_e[1] = 1;
    rpl_tab_d[2] = 64'h13; rpl_tab_s[2] = 1; rpl_tab_e[2] = 1;
    tlp_valid = 1; tlp_sop = 1; tlp_eop = 1; tlp_data = W'(64'h55);
    rpl_valid = 1;
    for (int i = 0; i < 3; i++) begin
      rpl_data = W'(rpl_tab_d[i]); rpl_sop = rpl_tab_s[i]; rpl_eop = rpl_tab_e[i];
      half();
      chk("rpl_prio.tlp_ready", tlp_ready, 1'b0);
      chk("rpl_prio.rpl_ready", rpl_ready, 1'b1);
      cyc();
      chk_out("rpl_prio.beat", 1'b1, rpl_tab_d[i], 2'd2);
    end
    rpl_valid = 0;
    half(); chk("rpl_prio.tlp_after", tlp_ready, 1'b1);
    cyc();  chk_out("rpl_prio.tlp", 1'b1, 64'h55, 2'd3);
    tlp_valid = 0;
    cyc();

    // INIT: DLLPs only
    dlcm_state = 2'b01;
    rpl_valid = 1; rpl_sop = 1; rpl_eop = 1; rpl_data = W'(64'h66);
    tlp_valid = 1; tlp_sop = 1; tlp_eop = 1; tlp_data = W'(64'h67);
    dllp_valid = 1; dllp_data = W'(64'hDE);
    for (int i = 0; i < 3; i++) begin
      half();
      chk("init.rpl_ready", rpl_ready, 1'b0);
      chk("init.tlp_ready", tlp_ready, 1'b0);
      cyc();
      chk_out("init.dllp", 1'b1, 64'hDE, 2'd1);
    end

    // link drops to INACTIVE mid-packet; packet completes
    dlcm_state = 2'b10; rpl_valid = 0; dllp_valid = 0;
    tlp_sop = 1; tlp_eop = 0; tlp_data = W'(64'hE1);
    cyc(); chk_out("drop.E1", 1'b1, 64'hE1, 2'd3);
    dlcm_state = 2'b00; tlp_sop = 0; tlp_eop = 1; tlp_data = W'(64'hE2);
    half(); chk("drop.rdyE2", tlp_ready, 1'b1);
    cyc();  chk_out("drop.E2", 1'b1, 64'hE2, 2'd3);
    tlp_sop = 1; tlp_eop = 1; tlp_data = W'(64'hE3);
    half(); chk("drop.rdy_inactive", tlp_ready, 1'b0);
    cyc();  chk("drop.idle", txvalid, 1'b0);
    tlp_valid = 0; dlcm_state = 2'b10;
    cyc();

    // sop=0 in IDLE is discarded with a one-cycle error pulse
    tlp_valid = 1; tlp_sop = 0; tlp_eop = 0; tlp_data = W'(64'hBAD);
    half(); chk("nosop.ready", tlp_ready, 1'b1);
    cyc();
    chk("nosop.err", proto_err, 1'b1);
    chk("nosop.valid", txvalid, 1'b0);
    chk("nosop.grant", grant, 2'd0);
    tlp_valid = 0;
    cyc(); chk("nosop.err_clear", proto_err, 1'b0);

    // sop repeated mid-packet is forwarded and flagged
    tlp_valid = 1; tlp_sop = 1; tlp_eop = 0; tlp_data = W'(64'h31);
    cyc(); chk("dupsop.first_err", proto_err, 1'b0);
    tlp_sop = 1; tlp_eop = 1; tlp_data = W'(64'h32);
    cyc();
    chk("dupsop.err", proto_err, 1'b1);
    chk_out("dupsop", 1'b1, 64'h32, 2'd3);
    tlp_valid = 0;
    cyc(); chk("dupsop.err_clear", proto_err, 1'b0);

    // reset mid-packet clears outputs and returns to IDLE
    tlp_valid = 1; tlp_sop = 1; tlp_eop = 0; tlp_data = W'(64'h41);
    cyc(); chk_out("rst.first", 1'b1, 64'h41, 2'd3);
    tlp_sop = 0; tlp_data = W'(64'h42); srst_n = 0;
    cyc();
    chk_out("rst.mid", 1'b0, 64'h0, 2'd0);
    chk("rst.err", proto_err, 1'b0);
    srst_n = 1; tlp_eop = 1; tlp_data = W'(64'h43);
    cyc();
    chk("rst.restart_err", proto_err, 1'b1);
    chk("rst.restart_valid", txvalid, 1'b0);
    tlp_valid = 0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dll_tx_arbiter.md
Name: dll_tx_arbiter

Overview:
- Shares the single PIPE transmit datapath between three DLL sources: replayed TLPs from the retry buffer, new TLPs, and DLLPs (ACK/NAK, InitFC, UpdateFC).
- Sits between the TLP-framing/retry logic, the DLLP generator and the PIPE TX interface.
- Arbitrates only at packet boundaries, gates traffic by link-control state, and bounds DLLP-induced TLP starvation.
- Registers its output with one cycle of latency.

Parameters:
- PIPE_DATA_WIDTH, 256, width of every data bus in bits.
- DLLP_BURST_MAX, 4, maximum consecutive DLLP grants while a TLP source is waiting; range 1..15.

Ports:
- sclk  input  1  system clock
- srst_n  input  1  synchronous active-low reset
- dlcm_state_i  input  2  link state: 2'b00 INACTIVE, 2'b01 INIT, 2'b10 ACTIVE, 2'b11 treated as INACTIVE
- rpl_valid_i  input  1  replay TLP beat valid
- rpl_data_i  input  PIPE_DATA_WIDTH  replay TLP beat
- rpl_sop_i  input  1  first beat of a replay TLP
- rpl_eop_i  input  1  last beat of a replay TLP
- rpl_ready_o  output  1  replay beat accepted
- tlp_valid_i  input  1  new TLP beat valid
- tlp_data_i  input  PIPE_DATA_WIDTH  new TLP beat
- tlp_sop_i  input  1  first beat of a new TLP
- tlp_eop_i  input  1  last beat of a new TLP
- tlp_ready_o  output  1  new TLP beat accepted
- dllp_valid_i  input  1  DLLP word valid (always a single beat)
- dllp_data_i  input  PIPE_DATA_WIDTH  DLLP word
- dllp_ready_o  output  1  DLLP word accepted
- pipe_txdata_o  output  PIPE_DATA_WIDTH  transmit word
- pipe_txvalid_o  output  1  transmit word valid
- grant_o  output  2  owner of last transmitted word: 0 none, 1 DLLP, 2 replay, 3 new TLP
- proto_err_o  output  1  one-cycle pulse on a framing violation

Behaviour:
- Transfer: a source beat transfers when its valid and ready are both high in the same cycle. Every ready is combinational from the FSM state, burst counter, dlcm_state_i and the valids. At most one ready is high per cycle.
- Latency: a beat transferred in cycle N appears on pipe_txdata_o with pipe_txvalid_o=1 in cycle N+1. There is no PIPE backpressure.
- Idle output: in cycles with no transfer, pipe_txvalid_o=0 and pipe_txdata_o holds its last value.
- Reset (srst_n=0 at a clock edge): FSM goes to IDLE, burst_cnt=0, pipe_txvalid_o=0, pipe_txdata_o=0, grant_o=0, proto_err_o=0. A packet in flight is abandoned; sources must restart at sop.
- FSM states: IDLE, LOCK_RPL, LOCK_TLP.
- IDLE selection, in priority order:
  1. Link INACTIVE: grant nothing.
  2. Link INIT: grant DLLP only.
  3. Link ACTIVE: a TLP is pending if rpl_valid_i, or tlp_valid_i with rpl_valid_i low.
  4. If a TLP is pending and burst_cnt==DLLP_BURST_MAX, grant the TLP.
  5. Else if dllp_valid_i, grant DLLP.
  6. Else grant replay if rpl_valid_i, otherwise new TLP.
  7. Replay strictly blocks new TLPs: tlp_ready_o=0 whenever rpl_valid_i=1 in IDLE.
- TLP start in IDLE:
  - A granted beat with sop=1 and eop=0 moves the FSM to LOCK_RPL or LOCK_TLP.
  - A granted beat with sop=1 and eop=1 (single-beat TLP) leaves the FSM in IDLE.
  - A granted beat with sop=0 is accepted and discarded (no pipe_txvalid_o), and proto_err_o pulses.
- LOCK_x states:
  - Only the owning source's ready follows its valid; all other readies are 0.
  - Beats are forwarded until a beat with eop=1 transfers, then the FSM returns to IDLE.
  - Valid low in a lock state inserts an idle cycle; lock is held.
  - sop=1 on a non-first beat: the beat is still forwarded and proto_err_o pulses.
  - A dlcm_state_i change mid-packet does not abort the packet. The new state applies at the next IDLE decision.
- burst_cnt (clog2(DLLP_BURST_MAX+1) bits):
  - Increments on each DLLP grant in IDLE while a TLP is pending.
  - Clears on any TLP sop grant, or on any IDLE cycle with no TLP pending.
  - Saturates at DLLP_BURST_MAX and never wraps.
- grant_o and proto_err_o are registered alongside pipe_txdata_o. A discarded beat sets grant_o=0.

Test Plan:
- Reset, then ACTIVE with dllp_valid_i held high and no TLPs -> one DLLP per cycle on pipe_txvalid_o from cycle 2, grant_o=1, burst_cnt stays 0.
- ACTIVE, 3-beat new TLP (data 0xA,0xB,0xC) with a DLLP arriving on beat 2 -> output A,B,C in consecutive cycles, then the DLLP; dllp_ready_o=0 during the lock.
- ACTIVE with DLLP and new TLP both always valid, DLLP_BURST_MAX=4 -> repeating output pattern D,D,D,D,T; 4 DLLPs then 1 TLP packet.
- rpl_valid_i and tlp_valid_i both high -> all replay packets are sent before any new TLP beat; tlp_ready_o=0 throughout.
- dlcm_state_i=INIT with all sources valid -> only DLLPs are sent. Switch to INACTIVE mid-way through a 2-beat TLP that began in ACTIVE -> both TLP beats are still sent, then pipe_txvalid_o=0.
- New TLP beat with sop=0 in IDLE -> proto_err_o=1 for exactly 1 cycle, pipe_txvalid_o=0. Assert srst_n=0 mid-packet -> all outputs are 0 on the next cycle.
